// File: rtl/posit_unpacker.sv
// posit_unpacker: decodes an N-bit posit into sign/seed/exp/frac fields, walking the regime one bit per cycle.
module posit_unpacker #(
    parameter int N  = 32,
    parameter int ES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  posit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sign,
    output logic [N-1:0]  seed,
    output logic [ES-1:0] exp,
    output logic [N-1:0]  frac,
    output logic          is_zero,
    output logic          is_nar
);
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t          r_state, w_next;
    logic [N-1:0]    r_sr;
    logic            r_run;
    logic [CW-1:0]   r_cnt;
    logic            r_sign, r_zero, r_nar;
    logic [N-1:0]    r_seed, r_frac;
    logic [ES-1:0]   r_exp;

    logic [N-1:0]    w_abs, w_sr_nx, w_k_ext;
    logic [CW-1:0]   w_cnt_inc, w_k;
    logic            w_match, w_done, w_special;

    assign w_abs     = posit[N-1] ? -posit : posit;
    assign w_special = (posit == '0) || (posit == NAR);
    assign w_match   = r_sr[N-1] == r_run;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_k       = w_match ? w_cnt_inc : r_cnt;
    // A run that swallows the whole body ends without a terminator.
    assign w_done    = !w_match || (w_cnt_inc == CW'(N-1));
    assign w_sr_nx   = r_sr << 1;
    assign w_k_ext   = N'(w_k);

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == EMIT;
    assign sign      = r_sign;
    assign seed      = r_seed;
    assign exp       = r_exp;
    assign frac      = r_frac;
    assign is_zero   = r_zero;
    assign is_nar    = r_nar;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? (w_special ? EMIT : SCAN) : IDLE;
            SCAN:    w_next = w_done ? EMIT : SCAN;
            EMIT:    w_next = out_ready ? IDLE : EMIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr   <= '0;
            r_run  <= 1'b0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_zero <= 1'b0;
            r_nar  <= 1'b0;
            r_seed <= '0;
            r_exp  <= '0;
            r_frac <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign <= posit[N-1];
                    r_zero <= posit == '0;
                    r_nar  <= posit == NAR;
                    r_seed <= '0;
                    r_exp  <= '0;
                    r_frac <= '0;
                    r_sr   <= w_abs << 1;
                    r_run  <= w_abs[N-2];
                    r_cnt  <= '0;
                end
                SCAN: begin
                    r_sr  <= w_sr_nx;
                    r_cnt <= w_k;
                    if (w_done) begin
                        r_seed <= r_run ? w_k_ext - N'(1) : -w_k_ext;
                        r_exp  <= w_sr_nx[N-1 -: ES];
                        r_frac <= w_sr_nx << ES;
                    end
                end
                EMIT: if (out_ready) begin
                    r_zero <= 1'b0;
                    r_nar  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
